ram: RTL and testbench



---
 rtl/ram.sv | 54 +++++
 tb/tb_ram.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ram.sv
// 32x32 single-port RAM with synchronous write and combinational read.
// Defining RAM_READ_REG_EN registers the read data with one cycle of latency.
module ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rst_n
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

    // An unknown ena/wena falls to the else branch, so mem is never written
    assign wr_en   = ena && wena;
    assign rd_en   = ena && !wena;
    assign rd_data = rd_en ? mem[addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= data_in;
        end
    end

`ifdef RAM_READ_REG_EN
    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_data;
        end
    end

    assign data_out = rd_q;
`else
    assign data_out = rst_n ? rd_data : '0;
`endif

endmodule

// File: tb/tb_ram.sv
// Directed scoreboard bench for ram; follows RAM_READ_REG_EN for read latency.
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    logic [31:0] exp_q [$];
    int          compared;
    int          mismatched;

    ram dut (
        .clk      (clk),
        .ena      (ena),
        .wena     (wena),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rst_n    (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        compared++;
        assert (data_out === e) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, data_out, e);
        end
    endtask

    task automatic read_wait();
`ifdef RAM_READ_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e,
                      input string tag);
        ena  = 1'b1;
        wena = 1'b0;
        addr = a;
        exp_q.push_back(e);
        read_wait();
        compare(tag);
    endtask

    task automatic idle(input string tag);
        ena  = 1'b0;
        wena = 1'b0;
        exp_q.push_back(32'h0);
        read_wait();
        compare(tag);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input string tag);
        ena     = 1'b1;
        wena    = 1'b1;
        addr    = a;
        data_in = d;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        ena        = 1'b0;
        wena       = 1'b0;
        addr       = '0;
        data_in    = '0;

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        compare("reset_out");
        rst_n = 1'b1;

        rd(5'd0, 32'h0, "reset_a0");
        rd(5'd2, 32'h0, "reset_a2");
        rd(5'd31, 32'h0, "reset_a31");

        // disabled write must be dropped
        ena     = 1'b0;
        wena    = 1'b1;
        addr    = 5'd2;
        data_in = 32'h0000_0001;
        exp_q.push_back(32'h0);
        @(posedge clk);
        #1;
        compare("dis_wr_out");
        rd(5'd2, 32'h0, "dis_wr_a2");

        wr(5'd2, 32'h0000_0080, "wr2_out");
        rd(5'd2, 32'h0000_0080, "rd2");
        idle("idle_out");

        wr(5'd0, 32'hDEAD_BEEF, "wr0_out");
        wr(5'd31, 32'h1234_5678, "wr31_out");
        rd(5'd0, 32'hDEAD_BEEF, "rd0");
        rd(5'd31, 32'h1234_5678, "rd31");
        rd(5'd2, 32'h0000_0080, "rd2_again");

        // reset pulse between edges while reading a live word
        rd(5'd0, 32'hDEAD_BEEF, "rd0_pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(32'h0);
        compare("rst_mid_out");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 32'h0, $sformatf("post_rst_a%0d", i));
        end

        // reset held across a write edge wins
        wr(5'd5, 32'h0000_0055, "wr5_out");
        rd(5'd5, 32'h0000_0055, "rd5");
        ena     = 1'b1;
        wena    = 1'b1;
        addr    = 5'd5;
        data_in = 32'h0000_00AA;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(5'd5, 32'h0, "rst_wr_a5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
